// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: frame-snapshot scanner driving eight active-low 7-seg digits.
// Define SEG7_SCAN_DIM_EN to add a per-frame 'dim' input (half drive window).
module seg7_scan_mux #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       enable,
    input  logic [6:0] D1Red7Seg0,
    input  logic [6:0] D1Red7Seg1,
    input  logic [6:0] D1Green7Seg0,
    input  logic [6:0] D1Green7Seg1,
    input  logic [6:0] D2Red7Seg0,
    input  logic [6:0] D2Red7Seg1,
    input  logic [6:0] D2Green7Seg0,
    input  logic [6:0] D2Green7Seg1,
`ifdef SEG7_SCAN_DIM_EN
    input  logic       dim,
`endif
    output logic [6:0] seg_n,
    output logic [7:0] dig_n,
    output logic [2:0] digit_idx,
    output logic       frame_start
);

    localparam int CW      = $clog2(DIV);
    localparam int DIM_END = BLANK + (DIV - BLANK) / 2;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    shadow_q [8];
    logic [6:0]    shadow_d [8];
    logic [6:0]    pats     [8];
    logic          dim_q, dim_d;
    logic          dim_in;
    logic [6:0]    seg_n_q, seg_n_d;
    logic [7:0]    dig_n_q, dig_n_d;
    logic          frame_start_q, frame_start_d;
    logic          load;
    logic          lit;

`ifdef SEG7_SCAN_DIM_EN
    assign dim_in = dim;
`else
    assign dim_in = 1'b0;
`endif

    // Drive window within a slot; dimming halves the post-blank part.
    function automatic logic in_window(input logic [CW-1:0] c,
                                       input logic dimmed);
        int ci;
        ci = int'(c);
        in_window = (ci >= BLANK) && (!dimmed || ci < DIM_END);
    endfunction

    always_comb begin
        pats = '{D1Red7Seg0, D1Red7Seg1, D1Green7Seg0, D1Green7Seg1,
                 D2Red7Seg0, D2Red7Seg1, D2Green7Seg0, D2Green7Seg1};
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        dim_d         = dim_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
            idx_d = '0;
            load  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            load  = (idx_q == 3'd7);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (load) begin
            shadow_d      = pats;
            dim_d         = dim_in;
            frame_start_d = 1'b1;
        end
        // Outputs are registered from next-state values, so they line up with state/cnt/idx.
        lit = enable && in_window(cnt_d, dim_d);
        if (!enable) begin
            state_d = S_IDLE;
        end else if (lit) begin
            state_d = S_DRIVE;
        end else begin
            state_d = S_BLANK;
        end
        seg_n_d = lit ? shadow_d[idx_d] : 7'h7F;
        dig_n_d = lit ? ~(8'b1 << idx_d) : 8'hFF;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            dim_q         <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 7'h7F;
            end
            seg_n_q       <= 7'h7F;
            dig_n_q       <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            dim_q         <= dim_d;
            shadow_q      <= shadow_d;
            seg_n_q       <= seg_n_d;
            dig_n_q       <= dig_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_n       = seg_n_q;
    assign dig_n       = dig_n_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_start_q;

endmodule
